// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//
// Contents:
//   state_t   - controller states (IDLE, RUN, DONE)
//   CNT_W     - bit counter width; sized for the largest legal WIDTH (16), so
//               one counter width serves every legal configuration (2..16)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH_MAX = 16;
  localparam int CNT_W         = $clog2(SUB_WIDTH_MAX);

endpackage

// File: rtl/sub_bit_cell.sv
// 1-bit full subtractor: d = x - y - bi (one bit), bo = borrow out.
//
// Ports:
//   x   in  minuend bit
//   y   in  subtrahend bit
//   bi  in  borrow in
//   d   out difference bit
//   bo  out borrow out
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y exceeds x, or when x == y and a borrow is already pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, LSB first, one bit
// per enabled clock, around a single sub_bit_cell.
//
// Handshake: start is sampled only in IDLE while ena=1; on acceptance a, b and
// b_in are captured, so they may change freely afterwards. busy is high for
// the WIDTH RUN cycles, done pulses for one cycle in DONE, and diff/b_out
// (plus ovf when built with it) are registered and held until the next
// completion. start seen in RUN or DONE is ignored, never queued. With ena=0
// every register holds, so an operation resumes exactly where it paused.
//
// Optional feature: define SUB_OVF_EN to add the ovf output (signed
// two's-complement overflow of the subtraction, held with diff).
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   ena         clock enable; 0 freezes all state
//   start       operation request
//   a, b, b_in  minuend, subtrahend, borrow in
//   busy, done  RUN indicator, one-cycle completion pulse
//   diff, b_out result and final borrow
//   ovf         signed overflow (SUB_OVF_EN only)
//   dbg_state   current controller state, for observation
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  state_t             state;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  // Holds the WIDTH-1 low result bits produced so far; the final bit is
  // joined directly into diff on the last edge.
  logic [WIDTH-2:0]   sd;
  logic               br;
  logic [CNT_W-1:0]   cnt;

  logic               d;
  logic               bo;
  logic [WIDTH-1:0]   sd_next;
  logic               last_bit;

`ifdef SUB_OVF_EN
  logic               a_msb;
  logic               b_msb;
`endif

  sub_bit_cell u_cell (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  assign sd_next   = {d, sd};
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= b_in;
            sd    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next[WIDTH-1:1];
          br  <= bo;
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff  <= sd_next;
            b_out <= bo;
`ifdef SUB_OVF_EN
            // Overflow only when operand signs differ and the result sign
            // departs from the minuend's.
            ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
